drr_pkt_scheduler: RTL and testbench

//  Deficit-round-robin packet scheduler; sits between the per-port rx queues and the shared datapath mux.

---
 rtl/drr_sched_pkg.sv | 38 +++
 rtl/drr_deficit_bank.sv | 71 +++++++
 rtl/drr_pkt_scheduler.sv | 176 +++++++++++++++++
 tb/tb_drr_pkt_scheduler.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drr_sched_pkg.sv
// Shared types, default widths and helper functions for the DRR packet scheduler.
package drr_sched_pkg;

    localparam int DRR_NUM_QUEUES      = 4;
    localparam int DRR_LEN_WIDTH       = 16;
    localparam int DRR_QUANTUM_WIDTH   = 16;
    localparam int DRR_DEFICIT_WIDTH   = 18;
    localparam int DRR_DEFAULT_QUANTUM = 1518;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADD       = 3'd1,
        ST_CHECK     = 3'd2,
        ST_GRANT     = 3'd3,
        ST_WAIT_DONE = 3'd4
    } drr_state_e;

    // Ceiling log2, used for index and address widths.
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max_val}) ? max_val : s[31:0];
    endfunction

endpackage

// File: rtl/drr_deficit_bank.sv
// Per-queue quantum and deficit storage for the DRR scheduler.
// One deficit update per cycle on the selected queue; quanta are written through the cfg port.
module drr_deficit_bank
    import drr_sched_pkg::*;
#(
    parameter int NUM_QUEUES      = DRR_NUM_QUEUES,
    parameter int LEN_WIDTH       = DRR_LEN_WIDTH,
    parameter int QUANTUM_WIDTH   = DRR_QUANTUM_WIDTH,
    parameter int DEFICIT_WIDTH   = DRR_DEFICIT_WIDTH,
    parameter int DEFAULT_QUANTUM = DRR_DEFAULT_QUANTUM,
    localparam int IDX_W          = log2(NUM_QUEUES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IDX_W-1:0]         sel_i,
    input  logic                     add_en_i,
    input  logic                     sub_en_i,
    input  logic                     clr_en_i,
    input  logic [LEN_WIDTH-1:0]     sub_len_i,
    output logic [DEFICIT_WIDTH-1:0] deficit_o,
    input  logic                     cfg_wr_en_i,
    input  logic [IDX_W-1:0]         cfg_idx_i,
    input  logic [QUANTUM_WIDTH-1:0] cfg_wr_data_i,
    output logic [QUANTUM_WIDTH-1:0] cfg_quantum_o
);

    localparam logic [31:0] DEFICIT_MAX = 32'((33'd1 << DEFICIT_WIDTH) - 33'd1);

    logic [DEFICIT_WIDTH-1:0] deficit_q [NUM_QUEUES];
    logic [QUANTUM_WIDTH-1:0] quantum_q [NUM_QUEUES];
    logic [DEFICIT_WIDTH-1:0] deficit_d;
    logic                     deficit_we;
    logic                     cfg_idx_ok;

    assign deficit_o     = deficit_q[sel_i];
    assign cfg_idx_ok    = 32'(cfg_idx_i) < NUM_QUEUES;
    assign cfg_quantum_o = cfg_idx_ok ? quantum_q[cfg_idx_i] : '0;

    // The FSM never requests more than one operation per cycle; clear has priority regardless.
    always_comb begin
        deficit_d  = deficit_o;
        deficit_we = 1'b0;
        if (clr_en_i) begin
            deficit_d  = '0;
            deficit_we = 1'b1;
        end else if (add_en_i) begin
            deficit_d  = DEFICIT_WIDTH'(sat_add(32'(deficit_o), 32'(quantum_q[sel_i]), DEFICIT_MAX));
            deficit_we = 1'b1;
        end else if (sub_en_i) begin
            deficit_d  = deficit_o - DEFICIT_WIDTH'(sub_len_i);
            deficit_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                deficit_q[q] <= '0;
                quantum_q[q] <= QUANTUM_WIDTH'(DEFAULT_QUANTUM);
            end
        end else begin
            if (deficit_we) begin
                deficit_q[sel_i] <= deficit_d;
            end
            if (cfg_wr_en_i && cfg_idx_ok) begin
                quantum_q[cfg_idx_i] <= cfg_wr_data_i;
            end
        end
    end

endmodule

// File: rtl/drr_pkt_scheduler.sv
// Deficit-round-robin packet scheduler: visit FSM, queue pointer, grant register and cfg readback.
// Define DRR_STATS_EN to build the per-queue 32-bit grant counters (cfg_addr MSB=1).
module drr_pkt_scheduler
    import drr_sched_pkg::*;
#(
    parameter int NUM_QUEUES      = DRR_NUM_QUEUES,
    parameter int LEN_WIDTH       = DRR_LEN_WIDTH,
    parameter int QUANTUM_WIDTH   = DRR_QUANTUM_WIDTH,
    parameter int DEFICIT_WIDTH   = DRR_DEFICIT_WIDTH,
    parameter int DEFAULT_QUANTUM = DRR_DEFAULT_QUANTUM,
    localparam int IDX_W          = log2(NUM_QUEUES),
    localparam int ADDR_W         = IDX_W + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_QUEUES-1:0]           head_valid_i,
    input  logic [NUM_QUEUES*LEN_WIDTH-1:0] head_len_i,
    output logic [NUM_QUEUES-1:0]           grant_o,
    output logic                            grant_valid_o,
    input  logic                            grant_ack_i,
    input  logic                            pkt_done_i,
    input  logic                            cfg_wr_en_i,
    input  logic                            cfg_rd_en_i,
    input  logic [ADDR_W-1:0]               cfg_addr_i,
    input  logic [QUANTUM_WIDTH-1:0]        cfg_wr_data_i,
    output logic [31:0]                     cfg_rd_data_o
);

    // state     | meaning
    // IDLE      | look at head_valid[cur]; empty queue loses its deficit and is passed over
    // ADD       | credit deficit[cur] with quantum[cur] (once per visit)
    // CHECK     | head fits in deficit -> GRANT, otherwise move on
    // GRANT     | grant_valid offered, wait for grant_ack, debit packet length
    // WAIT_DONE | grant held until pkt_done, then re-check the same queue

    drr_state_e               state_q, state_d;
    logic [IDX_W-1:0]         cur_queue_q, cur_queue_d;
    logic [NUM_QUEUES-1:0]    grant_q, grant_d;
    logic [31:0]              cfg_rd_data_q;

    logic [IDX_W-1:0]         next_queue;
    logic [LEN_WIDTH-1:0]     cur_len;
    logic [DEFICIT_WIDTH-1:0] cur_deficit;
    logic                     deficit_add, deficit_sub, deficit_clr;
    logic [IDX_W-1:0]         cfg_idx;
    logic [QUANTUM_WIDTH-1:0] cfg_quantum;
    logic [31:0]              stat_rd;

    assign cur_len    = head_len_i[int'(cur_queue_q) * LEN_WIDTH +: LEN_WIDTH];
    assign next_queue = (cur_queue_q == IDX_W'(NUM_QUEUES - 1)) ? '0 : cur_queue_q + 1'b1;
    assign cfg_idx    = cfg_addr_i[ADDR_W-2:0];

    drr_deficit_bank #(
        .NUM_QUEUES      (NUM_QUEUES),
        .LEN_WIDTH       (LEN_WIDTH),
        .QUANTUM_WIDTH   (QUANTUM_WIDTH),
        .DEFICIT_WIDTH   (DEFICIT_WIDTH),
        .DEFAULT_QUANTUM (DEFAULT_QUANTUM)
    ) u_bank (
        .clk           (clk),
        .reset         (reset),
        .sel_i         (cur_queue_q),
        .add_en_i      (deficit_add),
        .sub_en_i      (deficit_sub),
        .clr_en_i      (deficit_clr),
        .sub_len_i     (cur_len),
        .deficit_o     (cur_deficit),
        .cfg_wr_en_i   (cfg_wr_en_i && !cfg_addr_i[ADDR_W-1]),
        .cfg_idx_i     (cfg_idx),
        .cfg_wr_data_i (cfg_wr_data_i),
        .cfg_quantum_o (cfg_quantum)
    );

    always_comb begin
        state_d     = state_q;
        cur_queue_d = cur_queue_q;
        grant_d     = grant_q;
        deficit_add = 1'b0;
        deficit_sub = 1'b0;
        deficit_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (head_valid_i[cur_queue_q]) begin
                    state_d = ST_ADD;
                end else begin
                    deficit_clr = 1'b1;
                    cur_queue_d = next_queue;
                end
            end
            ST_ADD: begin
                deficit_add = 1'b1;
                state_d     = ST_CHECK;
            end
            ST_CHECK: begin
                if (!head_valid_i[cur_queue_q]) begin
                    deficit_clr = 1'b1;
                    cur_queue_d = next_queue;
                    state_d     = ST_IDLE;
                end else if (DEFICIT_WIDTH'(cur_len) <= cur_deficit) begin
                    grant_d = NUM_QUEUES'(1) << cur_queue_q;
                    state_d = ST_GRANT;
                end else begin
                    cur_queue_d = next_queue;
                    state_d     = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (grant_ack_i) begin
                    deficit_sub = 1'b1;
                    state_d     = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (pkt_done_i) begin
                    grant_d = '0;
                    state_d = ST_CHECK;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_queue_q <= '0;
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            cur_queue_q <= cur_queue_d;
            grant_q     <= grant_d;
        end
    end

`ifdef DRR_STATS_EN
    logic [31:0] stat_cnt_q [NUM_QUEUES];
    logic        cfg_idx_ok;

    assign cfg_idx_ok = 32'(cfg_idx) < NUM_QUEUES;
    assign stat_rd    = cfg_idx_ok ? stat_cnt_q[cfg_idx] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                stat_cnt_q[q] <= '0;
            end
        end else begin
            if (deficit_sub) begin
                stat_cnt_q[cur_queue_q] <= stat_cnt_q[cur_queue_q] + 32'd1;
            end
            // A clear landing on the same cycle as an increment wins.
            if (cfg_wr_en_i && cfg_addr_i[ADDR_W-1] && cfg_idx_ok) begin
                stat_cnt_q[cfg_idx] <= '0;
            end
        end
    end
`else
    assign stat_rd = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_rd_data_q <= '0;
        end else if (cfg_rd_en_i) begin
            cfg_rd_data_q <= cfg_addr_i[ADDR_W-1] ? stat_rd : 32'(cfg_quantum);
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = (state_q == ST_GRANT);
    assign cfg_rd_data_o = cfg_rd_data_q;

endmodule

// File: tb/tb_drr_pkt_scheduler.sv
// Self-checking bench for drr_pkt_scheduler: round-level DRR model feeds a grant scoreboard.
module tb_drr_pkt_scheduler;

    localparam int NQ = 4;
    localparam int LW = 16;
    localparam int QW = 16;
    localparam int DEF_MAX = (1 << 18) - 1;

`ifdef DRR_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NQ-1:0]   head_valid = '0;
    logic [NQ*LW-1:0] head_len = '0;
    logic [NQ-1:0]   grant_o;
    logic            grant_valid_o;
    logic            grant_ack = 1'b0;
    logic            pkt_done = 1'b0;
    logic            cfg_wr_en = 1'b0;
    logic            cfg_rd_en = 1'b0;
    logic [2:0]      cfg_addr = '0;
    logic [QW-1:0]   cfg_wr_data = '0;
    logic [31:0]     cfg_rd_data_o;

    int tests_run = 0;
    int tests_failed = 0;

    int exp_q[$];
    int m_len[NQ];
    int m_quant[NQ];
    int m_def[NQ];
    bit m_valid[NQ];
    int obs_cnt[NQ];
    int obs_bytes[NQ];

    always #5 clk = ~clk;

    drr_pkt_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .head_valid_i  (head_valid),
        .head_len_i    (head_len),
        .grant_o       (grant_o),
        .grant_valid_o (grant_valid_o),
        .grant_ack_i   (grant_ack),
        .pkt_done_i    (pkt_done),
        .cfg_wr_en_i   (cfg_wr_en),
        .cfg_rd_en_i   (cfg_rd_en),
        .cfg_addr_i    (cfg_addr),
        .cfg_wr_data_i (cfg_wr_data),
        .cfg_rd_data_o (cfg_rd_data_o)
    );

    task automatic init_model();
        for (int q = 0; q < NQ; q++) begin
            m_valid[q] = 1'b0;
            m_len[q]   = 64;
            m_quant[q] = 1518;
            m_def[q]   = 0;
        end
    endtask

    task automatic apply_heads();
        for (int q = 0; q < NQ; q++) begin
            head_valid[q] = m_valid[q];
            head_len[q*LW +: LW] = LW'(m_len[q]);
        end
    endtask

    // One DRR round in queue order; pushes each expected grant.
    task automatic push_round();
        for (int q = 0; q < NQ; q++) begin
            if (!m_valid[q]) begin
                m_def[q] = 0;
            end else begin
                m_def[q] = m_def[q] + m_quant[q];
                if (m_def[q] > DEF_MAX) m_def[q] = DEF_MAX;
                while (m_len[q] <= m_def[q]) begin
                    exp_q.push_back(q);
                    m_def[q] = m_def[q] - m_len[q];
                end
            end
        end
    endtask

    task automatic do_reset();
        grant_ack = 1'b0; pkt_done = 1'b0;
        cfg_wr_en = 1'b0; cfg_rd_en = 1'b0; cfg_addr = '0; cfg_wr_data = '0;
        apply_heads();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        for (int q = 0; q < NQ; q++) begin
            obs_cnt[q] = 0;
            obs_bytes[q] = 0;
        end
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [QW-1:0] data);
        cfg_wr_en = 1'b1; cfg_addr = addr; cfg_wr_data = data;
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    task automatic cfg_read(input logic [2:0] addr, output logic [31:0] data);
        cfg_rd_en = 1'b1; cfg_addr = addr;
        @(negedge clk);
        cfg_rd_en = 1'b0;
        data = cfg_rd_data_o;
    endtask

    // Acks every offered grant, pops the scoreboard and compares the one-hot select.
    task automatic serve(input int n, input int dly);
        int served;
        int cyc;
        int q;
        logic [NQ-1:0] exp_gnt;
        served = 0;
        cyc = 0;
        while (served < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (grant_valid_o) begin
                tests_run++;
                q = 0;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL serve_unexpected: grant=%b offered, scoreboard empty", grant_o);
                end else begin
                    q = exp_q.pop_front();
                    exp_gnt = '0;
                    exp_gnt[q] = 1'b1;
                    if (grant_o !== exp_gnt) begin
                        tests_failed++;
                        $display("FAIL serve_grant: got %b expected %b", grant_o, exp_gnt);
                    end
                end
                obs_cnt[q]++;
                obs_bytes[q] += m_len[q];
                grant_ack = 1'b1;
                @(negedge clk);
                grant_ack = 1'b0;
                repeat (dly - 1) @(negedge clk);
                pkt_done = 1'b1;
                @(negedge clk);
                pkt_done = 1'b0;
                served++;
            end
        end
        tests_run++;
        if (served != n) begin
            tests_failed++;
            $display("FAIL serve_timeout: served %0d grants, expected %0d", served, n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        init_model();
        do_reset();
        tests_run++;
        if (grant_o !== '0 || grant_valid_o !== 1'b0 || cfg_rd_data_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: grant=%b gv=%b rd=%0d expected 0/0/0", grant_o, grant_valid_o, cfg_rd_data_o);
        end
        tests_run++;
        if (dut.cur_queue_q !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_cur_queue: got %0d expected 0", dut.cur_queue_q);
        end
        for (int q = 0; q < NQ; q++) begin
            tests_run++;
            if (dut.u_bank.deficit_q[q] !== 18'd0) begin
                tests_failed++;
                $display("FAIL reset_deficit%0d: got %0d expected 0", q, dut.u_bank.deficit_q[q]);
            end
        end
        cfg_read(3'd3, rd);
        tests_run++;
        if (rd !== 32'd1518) begin
            tests_failed++;
            $display("FAIL reset_quantum: got %0d expected 1518", rd);
        end
    endtask

    task automatic test_single_queue();
        int lat;
        init_model();
        m_valid[0] = 1'b1;
        m_len[0] = 64;
        do_reset();
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (grant_valid_o) lat = k;
        end
        tests_run++;
        if (lat != 3 || grant_o !== 4'b0001) begin
            tests_failed++;
            $display("FAIL latency: got %0d cycles grant=%b expected 3 cycles grant=0001", lat, grant_o);
        end
        push_round();
        serve(23, 8);
        tests_run++;
        if (dut.u_bank.deficit_q[0] !== 18'(m_def[0]) || m_def[0] != 46) begin
            tests_failed++;
            $display("FAIL q0_residual: got %0d expected 46", dut.u_bank.deficit_q[0]);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (grant_valid_o !== 1'b0 || dut.u_bank.deficit_q[0] !== 18'd46) begin
            tests_failed++;
            $display("FAIL q0_hold: gv=%b deficit=%0d expected gv=0 deficit=46", grant_valid_o, dut.u_bank.deficit_q[0]);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (dut.u_bank.deficit_q[0] !== 18'(46 + 1518)) begin
            tests_failed++;
            $display("FAIL q0_recredit: got %0d expected %0d", dut.u_bank.deficit_q[0], 46 + 1518);
        end
    endtask

    task automatic test_fairness();
        int diff;
        init_model();
        m_valid[0] = 1'b1; m_len[0] = 1500;
        m_valid[1] = 1'b1; m_len[1] = 64;
        do_reset();
        push_round();
        serve(exp_q.size(), 2);
        tests_run++;
        if (obs_cnt[0] != 1 || obs_cnt[1] != 23) begin
            tests_failed++;
            $display("FAIL fair_counts: q0=%0d q1=%0d expected q0=1 q1=23", obs_cnt[0], obs_cnt[1]);
        end
        diff = obs_bytes[0] - obs_bytes[1];
        if (diff < 0) diff = -diff;
        tests_run++;
        if (diff > 1500) begin
            tests_failed++;
            $display("FAIL fair_bytes: byte difference %0d exceeds 1500", diff);
        end
        push_round();
        serve(exp_q.size(), 2);
        tests_run++;
        if (obs_cnt[1] != 23 + 24) begin
            tests_failed++;
            $display("FAIL fair_round2: q1 total %0d expected 47", obs_cnt[1]);
        end
    endtask

    task automatic test_small_quantum();
        logic [31:0] rd;
        init_model();
        do_reset();
        cfg_write(3'd2, 16'd500);
        cfg_read(3'd2, rd);
        tests_run++;
        if (rd !== 32'd500) begin
            tests_failed++;
            $display("FAIL cfg_quantum2: got %0d expected 500", rd);
        end
        m_quant[2] = 500; m_valid[2] = 1'b1; m_len[2] = 1200;
        apply_heads();
        push_round(); push_round(); push_round();
        serve(1, 3);
        tests_run++;
        if (dut.u_bank.deficit_q[2] !== 18'(m_def[2]) || m_def[2] != 300) begin
            tests_failed++;
            $display("FAIL q2_residual: got %0d expected 300", dut.u_bank.deficit_q[2]);
        end
    endtask

    task automatic test_drop_clears();
        int found;
        init_model();
        do_reset();
        cfg_write(3'd3, 16'd900);
        m_valid[3] = 1'b1; m_len[3] = 1000;
        apply_heads();
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            @(negedge clk);
            if (dut.u_bank.deficit_q[3] === 18'd900) found = 1;
        end
        tests_run++;
        if (found == 0) begin
            tests_failed++;
            $display("FAIL q3_credit: deficit never reached 900, got %0d", dut.u_bank.deficit_q[3]);
        end
        @(negedge clk);
        m_valid[3] = 1'b0;
        apply_heads();
        tests_run++;
        if (dut.u_bank.deficit_q[3] !== 18'd900 || grant_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL q3_retained: deficit=%0d gv=%b expected 900/0", dut.u_bank.deficit_q[3], grant_valid_o);
        end
        repeat (6) @(negedge clk);
        tests_run++;
        if (dut.u_bank.deficit_q[3] !== 18'd0) begin
            tests_failed++;
            $display("FAIL q3_cleared: got %0d expected 0", dut.u_bank.deficit_q[3]);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [31:0] rd;
        int found;
        init_model();
        m_valid[0] = 1'b1;
        do_reset();
        cfg_write(3'd0, 16'd2000);
        cfg_read(3'd0, rd);
        tests_run++;
        if (rd !== 32'd2000) begin
            tests_failed++;
            $display("FAIL cfg_quantum0: got %0d expected 2000", rd);
        end
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if (grant_valid_o) found = 1;
            else @(negedge clk);
        end
        grant_ack = 1'b1;
        @(negedge clk);
        grant_ack = 1'b0;
        tests_run++;
        if (found == 0 || grant_o !== 4'b0001 || grant_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_done_hold: grant=%b gv=%b expected 0001/0", grant_o, grant_valid_o);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (grant_o !== '0 || grant_valid_o !== 1'b0 || dut.cur_queue_q !== 2'd0 || cfg_rd_data_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL abort_outputs: grant=%b gv=%b cur=%0d rd=%0d expected all 0",
                     grant_o, grant_valid_o, dut.cur_queue_q, cfg_rd_data_o);
        end
        for (int q = 0; q < NQ; q++) begin
            tests_run++;
            if (dut.u_bank.deficit_q[q] !== 18'd0) begin
                tests_failed++;
                $display("FAIL abort_deficit%0d: got %0d expected 0", q, dut.u_bank.deficit_q[q]);
            end
        end
        reset = 1'b0;
        cfg_read(3'd0, rd);
        tests_run++;
        if (rd !== 32'd1518) begin
            tests_failed++;
            $display("FAIL abort_quantum: got %0d expected 1518", rd);
        end
    endtask

    task automatic test_stats();
        logic [31:0] rd;
        init_model();
        m_valid[1] = 1'b1;
        do_reset();
        for (int i = 0; i < 10; i++) exp_q.push_back(1);
        serve(10, 2);
        cfg_read(3'b101, rd);
        tests_run++;
        if (rd !== (STATS_ON ? 32'd10 : 32'd0)) begin
            tests_failed++;
            $display("FAIL stats_count: got %0d expected %0d", rd, STATS_ON ? 10 : 0);
        end
        cfg_write(3'b101, 16'd0);
        cfg_read(3'b101, rd);
        tests_run++;
        if (rd !== 32'd0) begin
            tests_failed++;
            $display("FAIL stats_clear: got %0d expected 0", rd);
        end
        cfg_wr_en = 1'b1; cfg_rd_en = 1'b1; cfg_addr = 3'd1; cfg_wr_data = 16'd777;
        @(negedge clk);
        cfg_wr_en = 1'b0; cfg_rd_en = 1'b0;
        tests_run++;
        if (cfg_rd_data_o !== 32'd1518) begin
            tests_failed++;
            $display("FAIL rd_during_wr: got %0d expected old value 1518", cfg_rd_data_o);
        end
        cfg_read(3'd1, rd);
        tests_run++;
        if (rd !== 32'd777) begin
            tests_failed++;
            $display("FAIL rd_after_wr: got %0d expected 777", rd);
        end
    endtask

    initial begin
        test_reset();
        test_single_queue();
        test_fairness();
        test_small_quantum();
        test_drop_clears();
        test_reset_mid_packet();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
